// File: rtl/mac_conv_sequencer.sv
// mac_conv_sequencer
//   Controller for one PE MAC (2x2..5x5 filter, 1-bit ifmap, FILTER_WIDTH-bit
//   weights). It accepts one layer config and loads N = size+2 filter rows.
//   It then walks every (row, col) of a dim x dim ofmap. For each position it
//   takes one ifmap window, issues one MAC op, and returns the result tagged
//   with its (row, col). Only one MAC op is outstanding at any time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid/ready/size/dim   layer config handshake (ready only in IDLE)
//   flt_valid/ready/data       filter rows, row1 first (ready only in LOAD)
//   win_valid/ready/data       ifmap window (ready only in FETCH)
//   mac_valid/ready            MAC request; mac_size, mac_row1..5, mac_ifmap
//   rsp_valid/ready/data       MAC result (ready only in WAIT)
//   out_valid/ready/data       tagged result, with out_row / out_col
//   done                       one-cycle pulse after the last result is taken
//
// Build option
//   MAC_SEQ_STALL_CNT_EN  adds stall_cnt[15:0]. It counts cycles spent in
//                         ISSUE with !mac_ready and in EMIT with !out_ready.
//                         It clears on cfg accept and saturates at all-ones.
//
// state  | meaning
// IDLE   | waiting for a layer config
// LOAD   | receiving filter rows 1..N
// FETCH  | waiting for the next ifmap window
// ISSUE  | presenting the MAC request
// WAIT   | waiting for the MAC result
// EMIT   | presenting the tagged result
// DONE   | one-cycle completion pulse
module mac_conv_sequencer #(
  parameter int FILTER_WIDTH = 8,
  parameter int OUTPUT_WIDTH = 12,
  parameter int DIM_W        = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [1:0]                cfg_size,
  input  logic [DIM_W-1:0]          cfg_dim,
  input  logic                      flt_valid,
  output logic                      flt_ready,
  input  logic [5*FILTER_WIDTH-1:0] flt_data,
  input  logic                      win_valid,
  output logic                      win_ready,
  input  logic [24:0]               win_data,
  output logic                      mac_valid,
  input  logic                      mac_ready,
  output logic [1:0]                mac_size,
  output logic [5*FILTER_WIDTH-1:0] mac_row1,
  output logic [5*FILTER_WIDTH-1:0] mac_row2,
  output logic [5*FILTER_WIDTH-1:0] mac_row3,
  output logic [5*FILTER_WIDTH-1:0] mac_row4,
  output logic [5*FILTER_WIDTH-1:0] mac_row5,
  output logic [24:0]               mac_ifmap,
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  logic [OUTPUT_WIDTH-1:0]   rsp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUTPUT_WIDTH-1:0]   out_data,
  output logic [DIM_W-1:0]          out_row,
  output logic [DIM_W-1:0]          out_col,
  output logic                      done
`ifdef MAC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int RW = 5 * FILTER_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_ISSUE, S_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              size_q;
  logic [DIM_W-1:0]        dim_q, row_q, col_q;
  logic [2:0]              row_idx_q;
  logic [RW-1:0]           filt_q [5];
  logic [24:0]             win_q;
  logic [OUTPUT_WIDTH-1:0] res_q;

  logic cfg_xfer, flt_xfer, win_xfer, mac_xfer, rsp_xfer, out_xfer;
  logic last_row_ld, last_col, last_pos;

  assign cfg_xfer = cfg_valid & cfg_ready;
  assign flt_xfer = flt_valid & flt_ready;
  assign win_xfer = win_valid & win_ready;
  assign mac_xfer = mac_valid & mac_ready;
  assign rsp_xfer = rsp_valid & rsp_ready;
  assign out_xfer = out_valid & out_ready;

  // The last filter row has index N-1, which equals size+1.
  assign last_row_ld = (row_idx_q == ({1'b0, size_q} + 3'd1));
  assign last_col    = (col_q == (dim_q - DIM_W'(1)));
  assign last_pos    = last_col && (row_q == (dim_q - DIM_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_xfer) state_d = (cfg_dim == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (flt_xfer && last_row_ld) state_d = S_FETCH;
      S_FETCH: if (win_xfer) state_d = S_ISSUE;
      S_ISSUE: if (mac_xfer) state_d = S_WAIT;
      S_WAIT:  if (rsp_xfer) state_d = S_EMIT;
      S_EMIT:  if (out_xfer) state_d = last_pos ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cfg_ready is gated by rst_n so that every output reads 0 while reset is held.
  always_comb begin
    cfg_ready = 1'b0;
    flt_ready = 1'b0;
    win_ready = 1'b0;
    mac_valid = 1'b0;
    rsp_ready = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE:  cfg_ready = rst_n;
      S_LOAD:  flt_ready = 1'b1;
      S_FETCH: win_ready = 1'b1;
      S_ISSUE: mac_valid = 1'b1;
      S_WAIT:  rsp_ready = 1'b1;
      S_EMIT:  out_valid = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q    <= '0;
      dim_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      row_idx_q <= '0;
      win_q     <= '0;
      res_q     <= '0;
      for (int k = 0; k < 5; k++) filt_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (cfg_xfer) begin
          size_q    <= cfg_size;
          dim_q     <= cfg_dim;
          row_q     <= '0;
          col_q     <= '0;
          row_idx_q <= '0;
          // Rows this filter size never loads must read as zero at the MAC.
          for (int k = 0; k < 5; k++)
            if (k > int'(cfg_size) + 1) filt_q[k] <= '0;
        end
        S_LOAD: if (flt_xfer) begin
          filt_q[row_idx_q] <= flt_data;
          row_idx_q         <= row_idx_q + 3'd1;
        end
        S_FETCH: if (win_xfer) win_q <= win_data;
        S_WAIT:  if (rsp_xfer) res_q <= rsp_data;
        S_EMIT: if (out_xfer) begin
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + DIM_W'(1);
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mac_size  = size_q;
  assign mac_row1  = filt_q[0];
  assign mac_row2  = filt_q[1];
  assign mac_row3  = filt_q[2];
  assign mac_row4  = filt_q[3];
  assign mac_row5  = filt_q[4];
  assign mac_ifmap = win_q;
  assign out_data  = res_q;
  assign out_row   = row_q;
  assign out_col   = col_q;

`ifdef MAC_SEQ_STALL_CNT_EN
  logic stall_evt;
  assign stall_evt = ((state_q == S_ISSUE) && !mac_ready) ||
                     ((state_q == S_EMIT)  && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cnt <= '0;
    else if (cfg_xfer)                      stall_cnt <= '0;
    else if (stall_evt && stall_cnt != '1)  stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mac_conv_sequencer.sv
module tb_mac_conv_sequencer;
  localparam int FW = 8;
  localparam int OW = 12;
  localparam int DW = 5;
  localparam int RW = 5 * FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [1:0]    cfg_size = '0;
  logic [DW-1:0] cfg_dim = '0;
  logic          flt_valid = 1'b0, flt_ready;
  logic [RW-1:0] flt_data = '0;
  logic          win_valid = 1'b0, win_ready;
  logic [24:0]   win_data = '0;
  logic          mac_valid, mac_ready = 1'b0;
  logic [1:0]    mac_size;
  logic [RW-1:0] mac_row1, mac_row2, mac_row3, mac_row4, mac_row5;
  logic [24:0]   mac_ifmap;
  logic          rsp_valid = 1'b0, rsp_ready;
  logic [OW-1:0] rsp_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [DW-1:0] out_row, out_col;
  logic          done;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  mac_conv_sequencer #(.FILTER_WIDTH(FW), .OUTPUT_WIDTH(OW), .DIM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_size(cfg_size), .cfg_dim(cfg_dim),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_size(mac_size),
    .mac_row1(mac_row1), .mac_row2(mac_row2), .mac_row3(mac_row3),
    .mac_row4(mac_row4), .mac_row5(mac_row5), .mac_ifmap(mac_ifmap),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .done(done)
`ifdef MAC_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int total = 0;
  int bad = 0;
  int n_flt = 0, n_win = 0, n_mac = 0, n_done = 0;

  always @(posedge clk) begin
    if (flt_valid && flt_ready) n_flt++;
    if (win_valid && win_ready) n_win++;
    if (mac_valid && mac_ready) n_mac++;
    if (done) n_done++;
  end

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] c;
    logic [OW-1:0] d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]    size;
    logic [DW-1:0] dim;
    int            base;
    bit            stall;
    bit            poke;
    int            exp_flt;
    int            exp_mac;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] get_row(input int k);
    case (k)
      0: return mac_row1;
      1: return mac_row2;
      2: return mac_row3;
      3: return mac_row4;
      default: return mac_row5;
    endcase
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return cfg_ready;
      1: return flt_ready;
      2: return win_ready;
      3: return mac_valid;
      4: return rsp_ready;
      5: return out_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where the DUT side is ready.
  task automatic wait_hi(input int sel, input string name);
    int n = 0;
    while (!sig(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: got ready=0 expected ready=1 within 50 cycles", name);
    end
  endtask

  task automatic run_conv(input vec_t v);
    int f0 = n_flt, w0 = n_win, m0 = n_mac, d0 = n_done;
    int nrows = int'(v.size) + 2;
    int dim = int'(v.dim);
    logic [RW-1:0] rows [5];
    logic [24:0]   win;
    exp_t          e;
    cfg_size = v.size;
    cfg_dim = v.dim;
    cfg_valid = 1'b1;
    wait_hi(0, "cfg");
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_size = 2'($urandom);
    cfg_dim = DW'($urandom);
    if (dim == 0) begin
      chk("done_dim0", done, 1);
    end else begin
      for (int r = 0; r < nrows; r++) begin
        rows[r] = {$urandom, $urandom};
        flt_data = rows[r];
        flt_valid = 1'b1;
        wait_hi(1, "flt");
        @(negedge clk);
        flt_valid = 1'b0;
      end
      for (int k = 0; k < 5; k++)
        chk($sformatf("mac_row%0d", k + 1), get_row(k), (k < nrows) ? rows[k] : '0);
      for (int p = 0; p < dim * dim; p++) begin
        if (v.poke && p == 0) begin
          cfg_valid = 1'b1;
          cfg_size = ~v.size;
          cfg_dim = v.dim + DW'(1);
          @(negedge clk);
          chk("cfg_ready_in_fetch", cfg_ready, 0);
          @(negedge clk);
          cfg_valid = 1'b0;
        end
        win = 25'($urandom);
        win_data = win;
        win_valid = 1'b1;
        wait_hi(2, "win");
        @(negedge clk);
        win_valid = 1'b0;
        mac_ready = 1'b1;
        wait_hi(3, "mac");
        chk("mac_ifmap", mac_ifmap, win);
        chk("mac_size", mac_size, v.size);
        @(negedge clk);
        mac_ready = 1'b0;
        e.r = DW'(p / dim);
        e.c = DW'(p % dim);
        e.d = OW'(v.base + p);
        sb.push_back(e);
        rsp_data = OW'(v.base + p);
        rsp_valid = 1'b1;
        wait_hi(4, "rsp");
        @(negedge clk);
        rsp_valid = 1'b0;
        if (v.stall && p == 1) begin
          for (int i = 0; i < 10; i++) begin
            chk("emit_hold", {out_valid, out_data, out_row, out_col}, {1'b1, sb[0].d, sb[0].r, sb[0].c});
            @(negedge clk);
          end
`ifdef MAC_SEQ_STALL_CNT_EN
          chk("stall_cnt", stall_cnt, 10);
`endif
        end
        out_ready = 1'b1;
        wait_hi(5, "out");
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got out_valid=1 expected no result");
        end else begin
          e = sb.pop_front();
          chk($sformatf("out_p%0d", p), {out_data, out_row, out_col}, {e.d, e.r, e.c});
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
      chk("done_pulse", done, 1);
    end
    @(negedge clk);
    chk("done_off", done, 0);
    chk("cfg_ready_end", cfg_ready, 1);
    chk("n_flt", n_flt - f0, v.exp_flt);
    chk("n_win", n_win - w0, v.exp_mac);
    chk("n_mac", n_mac - m0, v.exp_mac);
    chk("n_done", n_done - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tbl[0] = '{size: 2'd3, dim: 5'd1, base: 40,   stall: 0, poke: 0, exp_flt: 5, exp_mac: 1};
    tbl[1] = '{size: 2'd0, dim: 5'd2, base: 5,    stall: 0, poke: 0, exp_flt: 2, exp_mac: 4};
    tbl[2] = '{size: 2'd1, dim: 5'd0, base: 0,    stall: 0, poke: 0, exp_flt: 0, exp_mac: 0};
    tbl[3] = '{size: 2'd2, dim: 5'd2, base: 100,  stall: 1, poke: 0, exp_flt: 4, exp_mac: 4};
    tbl[4] = '{size: 2'd1, dim: 5'd3, base: 200,  stall: 0, poke: 1, exp_flt: 3, exp_mac: 9};
    tbl[5] = '{size: 2'd3, dim: 5'd2, base: 4090, stall: 0, poke: 0, exp_flt: 5, exp_mac: 4};

    #12;
    chk("rst_ctrl", {cfg_ready, flt_ready, win_ready, mac_valid, rsp_ready, out_valid, done}, 0);
    chk("rst_tags", {out_data, out_row, out_col, mac_size, mac_ifmap}, 0);
    chk("rst_rows", mac_row1 | mac_row2 | mac_row3 | mac_row4 | mac_row5, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cfg_ready_after_rst", cfg_ready, 1);

    for (int i = 0; i < 6; i++) run_conv(tbl[i]);

    // Reset while a MAC op is outstanding.
    cfg_size = 2'd0;
    cfg_dim = 5'd2;
    cfg_valid = 1'b1;
    wait_hi(0, "cfg_r");
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      flt_data = {$urandom, $urandom} | 40'h1;
      flt_valid = 1'b1;
      wait_hi(1, "flt_r");
      @(negedge clk);
      flt_valid = 1'b0;
    end
    win_data = 25'h1ABCDEF;
    win_valid = 1'b1;
    wait_hi(2, "win_r");
    @(negedge clk);
    win_valid = 1'b0;
    mac_ready = 1'b1;
    wait_hi(3, "mac_r");
    @(negedge clk);
    mac_ready = 1'b0;
    chk("in_wait", rsp_ready, 1);
    d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {cfg_ready, flt_ready, win_ready, mac_valid, rsp_ready, out_valid, done}, 0);
    chk("midrst_tags", {out_data, out_row, out_col, mac_size, mac_ifmap}, 0);
    chk("midrst_rows", mac_row1 | mac_row2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cfg_ready_after_midrst", cfg_ready, 1);
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", n_done - d0, 0);
    chk("no_out_after_rst", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
